// File: rtl/serial_mag_compare.sv
// rtl/serial_mag_compare.sv - bit-serial MSB-first unsigned magnitude comparator with start/done handshake
// One bit pair per clock through a 1-bit eq/gt/lt cell; exits at the first differing bit.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic             bit_a, bit_b;
    logic             cell_gt, cell_lt;

    // 1-bit comparator cell on the currently selected bit pair
    always_comb begin
        bit_a   = a_q[idx_q];
        bit_b   = b_q[idx_q];
        cell_gt = bit_a & ~bit_b;
        cell_lt = ~bit_a & bit_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    idx_d   = IDX_MSB;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = CMP;
                end
            end
            CMP: begin
                if (cell_gt || cell_lt) begin
                    eq_d    = 1'b0;
                    gt_d    = cell_gt;
                    lt_d    = cell_lt;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign eq_o   = eq_q;
    assign gt_o   = gt_q;
    assign lt_o   = lt_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb/tb_serial_mag_compare.sv - self-checking bench for serial_mag_compare
// Reference: plain unsigned compare plus latency from the highest differing bit.
module tb_serial_mag_compare;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, eq_o, gt_o, lt_o;

    int n_checks = 0;
    int n_errors = 0;

    serial_mag_compare #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .eq_o    (eq_o),
        .gt_o    (gt_o),
        .lt_o    (lt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_result(input logic [W-1:0] av, input logic [W-1:0] bv);
        return {av == bv, av > bv, av < bv};
    endfunction

    // compare cycles = bits from the MSB down to the deciding bit inclusive
    function automatic int ref_cycles(input logic [W-1:0] av, input logic [W-1:0] bv);
        int p = 0;
        for (int i = 0; i < W; i++) if (av[i] != bv[i]) p = i;
        return W - p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT idle; returns one step after the trailing IDLE edge.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit poke);
        int k;
        int ncmp;
        int dones;
        logic [2:0] res;
        ncmp  = ref_cycles(av, bv);
        res   = ref_result(av, bv);
        dones = 0;
        start_i = 1'b1;
        a_i     = av;
        b_i     = bv;
        tick();
        start_i = 1'b0;
        a_i     = W'($urandom);
        b_i     = W'($urandom);
        check("accept_busy", busy_o, 1);
        check("accept_clear", {eq_o, gt_o, lt_o}, 3'b000);
        k = 0;
        while (!done_o && k <= W + 2) begin
            check("cmp_result_zero", {eq_o, gt_o, lt_o}, 3'b000);
            check("cmp_busy", busy_o, 1);
            if (poke && k == 1) begin
                start_i = 1'b1;
                a_i     = 8'h00;
                b_i     = 8'hFF;
            end else begin
                start_i = 1'b0;
            end
            tick();
            k++;
        end
        start_i = 1'b0;
        if (done_o) dones++;
        check("done_latency", k, ncmp);
        check("done_result", {eq_o, gt_o, lt_o}, res);
        check("done_busy", busy_o, 1);
        a_i = W'($urandom);
        b_i = W'($urandom);
        tick();
        check("idle_done_low", done_o, 0);
        check("idle_busy_low", busy_o, 0);
        check("idle_result_hold", {eq_o, gt_o, lt_o}, res);
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                if (done_o) dones++;
            end
            check("single_done_pulse", dones, 1);
            check("poke_result_hold", {eq_o, gt_o, lt_o}, res);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst     = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (2) tick();
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_eq", eq_o, 0);
        check("reset_gt", gt_o, 0);
        check("reset_lt", lt_o, 0);
        rst = 1'b0;
        tick();

        run_cmp(8'hA5, 8'hA5, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b0);
        run_cmp(8'h12, 8'h13, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a_i = W'($urandom);
            b_i = W'($urandom);
            tick();
            check("no_start_hold", {eq_o, gt_o, lt_o, done_o, busy_o}, 5'b00100);
        end
        run_cmp(8'h40, 8'h20, 1'b1);

        // asynchronous reset between edges 3 and 4 of a long compare
        start_i = 1'b1;
        a_i     = 8'h0F;
        b_i     = 8'h0E;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {busy_o, done_o, eq_o, gt_o, lt_o}, 5'b00000);
        check("async_rst_idx", dut.idx_q, 0);
        check("async_rst_ops", {dut.a_q, dut.b_q}, 0);
        tick();
        check("rst_held_outputs", {busy_o, done_o, eq_o, gt_o, lt_o}, 5'b00000);
        rst = 1'b0;
        tick();
        run_cmp(8'h01, 8'h02, 1'b0);

        // start held high continuously: accept, CMP, DONE, IDLE-accept ...
        start_i = 1'b1;
        a_i     = 8'h55;
        b_i     = 8'hAA;
        tick();
        for (int r = 0; r < 4; r++) begin
            check("b2b_cmp", {busy_o, done_o, eq_o, gt_o, lt_o}, 5'b10000);
            tick();
            check("b2b_done", {busy_o, done_o, eq_o, gt_o, lt_o}, 5'b11001);
            tick();
            check("b2b_idle", {busy_o, done_o, eq_o, gt_o, lt_o}, 5'b00001);
            tick();
        end
        start_i = 1'b0;
        repeat (4) tick();

        for (int n = 0; n < 150; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            run_cmp(ra, rb, 1'($urandom_range(0, 7) == 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
